// File: rtl/adder_axi_pkg.sv
// adder_axi_pkg: shared state encoding, default register map and response
// encoding for the adder AXI4-Lite master.
package adder_axi_pkg;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_A   = 3'd1;
    localparam logic [2:0] WR_B   = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] RD     = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;
    localparam int unsigned DEF_OPA_ADDR = 0;
    localparam int unsigned DEF_OPB_ADDR = 4;
    localparam int unsigned DEF_RES_ADDR = 24;
    localparam logic RESP_ERR = 1'b1;
endpackage

// File: rtl/adder_axi_master_if.sv
// adder_axi_master_if: command/response port plus the AXI4-Lite bus toward
// the adder slave, with master and slave views.
interface adder_axi_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [DATA_WIDTH-1:0]   cmd_a;
    logic [DATA_WIDTH-1:0]   cmd_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_sum;
    logic                    rsp_err;
    logic [ADDR_WIDTH-1:0]   m1_axi_awaddr;
    logic                    m1_axi_awvalid;
    logic                    m1_axi_awready;
    logic [DATA_WIDTH-1:0]   m1_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m1_axi_wstrb;
    logic                    m1_axi_wvalid;
    logic                    m1_axi_wready;
    logic                    m1_axi_bresp;
    logic                    m1_axi_bvalid;
    logic                    m1_axi_bready;
    logic [ADDR_WIDTH-1:0]   m1_axi_araddr;
    logic                    m1_axi_arvalid;
    logic                    m1_axi_arready;
    logic [DATA_WIDTH-1:0]   m1_axi_rdata;
    logic                    m1_axi_rresp;
    logic                    m1_axi_rvalid;
    logic                    m1_axi_rready;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, rsp_ready,
        input  m1_axi_awready, m1_axi_wready, m1_axi_bresp, m1_axi_bvalid,
        input  m1_axi_arready, m1_axi_rdata, m1_axi_rresp, m1_axi_rvalid,
        output cmd_ready, rsp_valid, rsp_sum, rsp_err,
        output m1_axi_awaddr, m1_axi_awvalid, m1_axi_wdata, m1_axi_wstrb, m1_axi_wvalid,
        output m1_axi_bready, m1_axi_araddr, m1_axi_arvalid, m1_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, rsp_ready,
        output m1_axi_awready, m1_axi_wready, m1_axi_bresp, m1_axi_bvalid,
        output m1_axi_arready, m1_axi_rdata, m1_axi_rresp, m1_axi_rvalid,
        input  cmd_ready, rsp_valid, rsp_sum, rsp_err,
        input  m1_axi_awaddr, m1_axi_awvalid, m1_axi_wdata, m1_axi_wstrb, m1_axi_wvalid,
        input  m1_axi_bready, m1_axi_araddr, m1_axi_arvalid, m1_axi_rready
    );
endinterface

// File: rtl/axi_lite_wr_chan.sv
// axi_lite_wr_chan: one AXI4-Lite write (AW + W with independent handshakes,
// then B); reloaded by start for each write of a command.
module axi_lite_wr_chan
    import adder_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  awready,
    input  logic                  wready,
    input  logic                  bvalid,
    input  logic                  bresp,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    output logic                  bready,
    output logic                  done,
    output logic                  err
);
    logic aw_done, w_done;

    // a B beat only counts once both AW and W handshakes are already registered
    assign done = bready && bvalid && aw_done && w_done;
    assign err  = bresp == RESP_ERR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awaddr  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (start) begin
            awaddr  <= addr;
            wdata   <= data;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            bready  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                awvalid <= 1'b0;
                aw_done <= 1'b1;
            end
            if (wvalid && wready) begin
                wvalid <= 1'b0;
                w_done <= 1'b1;
            end
            if (done) bready <= 1'b0;
        end
    end
endmodule

// File: rtl/adder_axi_master.sv
// adder_axi_master: writes operand A then B to the adder slave, waits a settle
// time, reads the sum back and returns it with an accumulated error flag.
module adder_axi_master
    import adder_axi_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDR_WIDTH    = 8,
    parameter int unsigned OPA_ADDR      = DEF_OPA_ADDR,
    parameter int unsigned OPB_ADDR      = DEF_OPB_ADDR,
    parameter int unsigned RES_ADDR      = DEF_RES_ADDR,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                m1_axi_aclk,
    input  logic                m1_axi_aresetn,
    adder_axi_master_if.master  bus
);
    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] b_q;
    logic [7:0]            cnt;
    logic                  err_acc;
    logic                  accept, wr_start, wr_done, wr_err, settle_done;

    assign bus.cmd_ready    = (state == IDLE) && m1_axi_aresetn;
    assign bus.m1_axi_wstrb = '1;
    assign accept           = bus.cmd_valid && bus.cmd_ready;
    // the B beat that ends operand A immediately launches operand B
    assign wr_start         = accept || (state == WR_A && wr_done);
    assign settle_done      = ({1'b0, cnt} + 9'd1) >= 9'(SETTLE_CYCLES);

    axi_lite_wr_chan #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) wr_chan (
        .clk     (m1_axi_aclk),
        .rst_n   (m1_axi_aresetn),
        .start   (wr_start),
        .addr    (state == IDLE ? ADDR_WIDTH'(OPA_ADDR) : ADDR_WIDTH'(OPB_ADDR)),
        .data    (state == IDLE ? bus.cmd_a : b_q),
        .awready (bus.m1_axi_awready),
        .wready  (bus.m1_axi_wready),
        .bvalid  (bus.m1_axi_bvalid),
        .bresp   (bus.m1_axi_bresp),
        .awaddr  (bus.m1_axi_awaddr),
        .awvalid (bus.m1_axi_awvalid),
        .wdata   (bus.m1_axi_wdata),
        .wvalid  (bus.m1_axi_wvalid),
        .bready  (bus.m1_axi_bready),
        .done    (wr_done),
        .err     (wr_err)
    );

    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state              <= IDLE;
            b_q                <= '0;
            cnt                <= '0;
            err_acc            <= 1'b0;
            bus.m1_axi_araddr  <= '0;
            bus.m1_axi_arvalid <= 1'b0;
            bus.m1_axi_rready  <= 1'b0;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_sum        <= '0;
            bus.rsp_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    b_q     <= bus.cmd_b;
                    err_acc <= 1'b0;
                    state   <= WR_A;
                end
                WR_A: if (wr_done) begin
                    err_acc <= err_acc | wr_err;
                    state   <= WR_B;
                end
                WR_B: if (wr_done) begin
                    err_acc <= err_acc | wr_err;
                    cnt     <= '0;
                    state   <= SETTLE;
                end
                SETTLE: if (settle_done) begin
                    bus.m1_axi_arvalid <= 1'b1;
                    bus.m1_axi_araddr  <= ADDR_WIDTH'(RES_ADDR);
                    state              <= RD;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                RD: begin
                    if (bus.m1_axi_arvalid && bus.m1_axi_arready) begin
                        bus.m1_axi_arvalid <= 1'b0;
                        bus.m1_axi_rready  <= 1'b1;
                    end
                    if (bus.m1_axi_rvalid && bus.m1_axi_rready) begin
                        bus.rsp_sum       <= bus.m1_axi_rdata;
                        bus.rsp_err       <= err_acc | (bus.m1_axi_rresp == RESP_ERR);
                        bus.m1_axi_rready <= 1'b0;
                        bus.rsp_valid     <= 1'b1;
                        state             <= RESP;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_axi_master.sv
// tb_adder_axi_master: directed tests of the adder AXI master against a small
// registered model of the adder slave.
module tb_adder_axi_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_axi_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    adder_axi_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .OPA_ADDR(0), .OPB_ADDR(4),
        .RES_ADDR(24), .SETTLE_CYCLES(2)
    ) dut (
        .m1_axi_aclk    (clk),
        .m1_axi_aresetn (rst_n),
        .bus            (bus)
    );

    int checks = 0;
    int failures = 0;
    int lat = 0;

    // slave model: operand registers at 0/4, sum readable at 24
    logic [7:0]  aw_delay = 8'd0;
    logic [7:0]  berr_idx = 8'hFF;
    logic [7:0]  aw_cnt, n_wr, n_rd, s_awaddr, e_addr;
    logic [31:0] s_wdata, e_data, reg_a, reg_b;
    logic        got_aw, got_w, aw_hs, w_hs;
    logic [7:0]  log_addr [8];
    logic [31:0] log_data [8];

    assign bus.m1_axi_awready = aw_cnt >= aw_delay;
    assign bus.m1_axi_wready  = 1'b1;
    assign bus.m1_axi_arready = 1'b1;
    assign aw_hs  = bus.m1_axi_awvalid && bus.m1_axi_awready;
    assign w_hs   = bus.m1_axi_wvalid && bus.m1_axi_wready;
    assign e_addr = got_aw ? s_awaddr : bus.m1_axi_awaddr;
    assign e_data = got_w ? s_wdata : bus.m1_axi_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; got_aw <= 0; got_w <= 0; s_awaddr <= 0; s_wdata <= 0;
            reg_a <= 0; reg_b <= 0; n_wr <= 0; n_rd <= 0;
            bus.m1_axi_bvalid <= 0; bus.m1_axi_bresp <= 0;
            bus.m1_axi_rvalid <= 0; bus.m1_axi_rdata <= 0; bus.m1_axi_rresp <= 0;
        end else begin
            aw_cnt <= (aw_hs || !bus.m1_axi_awvalid) ? 8'd0 : aw_cnt + 8'd1;
            if (aw_hs) begin got_aw <= 1; s_awaddr <= bus.m1_axi_awaddr; end
            if (w_hs) begin got_w <= 1; s_wdata <= bus.m1_axi_wdata; end
            if (bus.m1_axi_bvalid && bus.m1_axi_bready) bus.m1_axi_bvalid <= 0;
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                got_aw <= 0; got_w <= 0;
                bus.m1_axi_bvalid <= 1;
                bus.m1_axi_bresp  <= n_wr == berr_idx;
                log_addr[n_wr[2:0]] <= e_addr;
                log_data[n_wr[2:0]] <= e_data;
                n_wr <= n_wr + 8'd1;
                if (e_addr == 8'd0) reg_a <= e_data;
                if (e_addr == 8'd4) reg_b <= e_data;
            end
            if (bus.m1_axi_rvalid && bus.m1_axi_rready) bus.m1_axi_rvalid <= 0;
            if (bus.m1_axi_arvalid) begin
                bus.m1_axi_rvalid <= 1;
                bus.m1_axi_rdata  <= (bus.m1_axi_araddr == 8'd24) ? reg_a + reg_b : 32'd0;
                n_rd <= n_rd + 8'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // call at a negedge; lat=1 marks the accept cycle, returns one cycle later
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
        chk1("cmd_ready_wait", bus.cmd_ready, 1'b1);
        lat = 1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 2;
    endtask

    task automatic wait_rsp();
        while (!bus.rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk1("rsp_valid_wait", bus.rsp_valid, 1'b1);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    logic [7:0] n0, r0, i0, i1;
    logic       seen;

    initial begin
        bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.rsp_ready = 0;
        repeat (3) @(negedge clk);
        chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk1("rst_awvalid", bus.m1_axi_awvalid, 1'b0);
        chk1("rst_wvalid", bus.m1_axi_wvalid, 1'b0);
        chk1("rst_arvalid", bus.m1_axi_arvalid, 1'b0);
        chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_wstrb", 32'(bus.m1_axi_wstrb), 32'hF);
        chk("rst_awaddr", 32'(bus.m1_axi_awaddr), 32'd0);
        rst_n = 1'b1;
        #1 chk1("release_cmd_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);

        // basic 39 + 40 with an always-ready slave
        n0 = n_wr; r0 = n_rd; i0 = n0; i1 = n0 + 8'd1;
        issue(32'd39, 32'd40);
        wait_rsp();
        chk("t1_latency", 32'(lat), 32'd10);
        chk("t1_sum", bus.rsp_sum, 32'd79);
        chk1("t1_err", bus.rsp_err, 1'b0);
        chk("t1_nwr", 32'(n_wr - n0), 32'd2);
        chk("t1_nrd", 32'(n_rd - r0), 32'd1);
        chk("t1_wr0_addr", 32'(log_addr[i0[2:0]]), 32'd0);
        chk("t1_wr0_data", log_data[i0[2:0]], 32'd39);
        chk("t1_wr1_addr", 32'(log_addr[i1[2:0]]), 32'd4);
        chk("t1_wr1_data", log_data[i1[2:0]], 32'd40);
        consume();
        chk1("t1_rsp_cleared", bus.rsp_valid, 1'b0);

        // awready held off three cycles, wready immediate
        aw_delay = 8'd3;
        issue(32'd100, 32'd23);
        chk1("t2_both_valid", bus.m1_axi_awvalid & bus.m1_axi_wvalid, 1'b1);
        @(negedge clk); lat++;
        chk1("t2_wvalid_dropped", bus.m1_axi_wvalid, 1'b0);
        chk1("t2_awvalid_held", bus.m1_axi_awvalid, 1'b1);
        @(negedge clk); lat++;
        chk1("t2_awvalid_held2", bus.m1_axi_awvalid, 1'b1);
        chk("t2_awaddr_stable", 32'(bus.m1_axi_awaddr), 32'd0);
        wait_rsp();
        chk("t2_latency", 32'(lat), 32'd16);
        chk("t2_sum", bus.rsp_sum, 32'd123);
        chk1("t2_err", bus.rsp_err, 1'b0);
        aw_delay = 8'd0;
        consume();

        // error response on the second write
        n0 = n_wr; r0 = n_rd;
        berr_idx = n_wr + 8'd1;
        issue(32'd7, 32'd8);
        wait_rsp();
        chk1("t3_err", bus.rsp_err, 1'b1);
        chk("t3_sum", bus.rsp_sum, 32'd15);
        chk("t3_nwr", 32'(n_wr - n0), 32'd2);
        chk("t3_nrd", 32'(n_rd - r0), 32'd1);
        berr_idx = 8'hFF;
        consume();

        // consumer stalls for five cycles with a new command pending
        issue(32'd1000, 32'd2000);
        wait_rsp();
        chk("t4_sum", bus.rsp_sum, 32'd3000);
        bus.cmd_a = 32'd5; bus.cmd_b = 32'd6; bus.cmd_valid = 1'b1;
        n0 = n_wr;
        repeat (5) begin
            @(negedge clk);
            chk1("t4_rsp_valid_hold", bus.rsp_valid, 1'b1);
            chk("t4_sum_hold", bus.rsp_sum, 32'd3000);
            chk1("t4_cmd_ready_low", bus.cmd_ready, 1'b0);
        end
        chk("t4_no_new_write", 32'(n_wr - n0), 32'd0);
        bus.cmd_valid = 1'b0;
        consume();
        chk1("t4_rsp_done", bus.rsp_valid, 1'b0);
        chk1("t4_cmd_ready_back", bus.cmd_ready, 1'b1);

        // reset while operand B's address is still pending
        aw_delay = 8'd3;
        issue(32'd11, 32'd22);
        for (int i = 0; i < 50 && !(bus.m1_axi_awvalid && bus.m1_axi_awaddr == 8'd4); i++)
            @(negedge clk);
        chk1("t5_reached_wr_b", bus.m1_axi_awvalid && bus.m1_axi_awaddr == 8'd4, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("t5_awvalid", bus.m1_axi_awvalid, 1'b0);
        chk1("t5_wvalid", bus.m1_axi_wvalid, 1'b0);
        chk1("t5_bready", bus.m1_axi_bready, 1'b0);
        chk1("t5_arvalid", bus.m1_axi_arvalid, 1'b0);
        chk1("t5_cmd_ready", bus.cmd_ready, 1'b0);
        @(negedge clk);
        aw_delay = 8'd0;
        rst_n = 1'b1;
        #1 chk1("t5_cmd_ready_release", bus.cmd_ready, 1'b1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid | bus.m1_axi_awvalid | bus.m1_axi_arvalid;
        end
        chk1("t5_no_activity", seen, 1'b0);

        // wrap-around
        issue(32'hFFFF_FFFF, 32'd1);
        wait_rsp();
        chk("t6_latency", 32'(lat), 32'd10);
        chk("t6_sum", bus.rsp_sum, 32'd0);
        chk1("t6_err", bus.rsp_err, 1'b0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_axi_master.md
Name: adder_axi_master

Overview:
AXI4-Lite master that sits directly upstream of the adder register slave and drives its s1_axi port. It accepts an operand pair over a valid/ready command port and writes operand A to OPA_ADDR, then operand B to OPB_ADDR. It waits a fixed settle time, reads the sum from RES_ADDR, and returns the sum plus an error flag over a valid/ready response port. It replaces hand-driven bus stimulus for the adder.

Parameters:
DATA_WIDTH, 32, AXI data and operand width
ADDR_WIDTH, 8, AXI address width
OPA_ADDR, 0, byte address of operand A register
OPB_ADDR, 4, byte address of operand B register
RES_ADDR, 24, byte address of result register
SETTLE_CYCLES, 2, idle cycles between last write response and read address (range 0..255)

Ports:
m1_axi_aclk  in  1  clock
m1_axi_aresetn  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  operand pair valid
cmd_ready  out  1  master idle, can accept command
cmd_a  in  DATA_WIDTH  operand A
cmd_b  in  DATA_WIDTH  operand B
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_sum  out  DATA_WIDTH  value read from RES_ADDR
rsp_err  out  1  OR of all bresp/rresp for this command
m1_axi_awaddr  out  ADDR_WIDTH  write address
m1_axi_awvalid  out  1
m1_axi_awready  in  1
m1_axi_wdata  out  DATA_WIDTH
m1_axi_wstrb  out  DATA_WIDTH/8  always all ones
m1_axi_wvalid  out  1
m1_axi_wready  in  1
m1_axi_bresp  in  1  1 = error (matches adder slave width)
m1_axi_bvalid  in  1
m1_axi_bready  out  1
m1_axi_araddr  out  ADDR_WIDTH
m1_axi_arvalid  out  1
m1_axi_arready  in  1
m1_axi_rdata  in  DATA_WIDTH
m1_axi_rresp  in  1  1 = error
m1_axi_rvalid  in  1
m1_axi_rready  out  1

Behaviour:
- Reset (m1_axi_aresetn low, async): state IDLE; all valid/ready outputs 0; addresses, wdata, rsp_sum, rsp_err 0; wstrb all ones; settle counter 0; cmd_ready 0 during reset, 1 in the first cycle after release.
- FSM states: IDLE, WR_A, WR_B, SETTLE, RD, RESP. All outputs registered.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_a/cmd_b, clear err accumulator, go WR_A. The next cycle drives awvalid=wvalid=1, awaddr=OPA_ADDR, wdata=A.
- Write phase (WR_A, WR_B):
  - awvalid and wvalid rise together. Each drops the cycle after its own handshake (valid&ready sampled high); they are tracked independently, so either order or the same cycle is legal.
  - Neither valid may drop before its handshake. Address and data stay stable while valid.
  - bready=1 throughout the state. The phase ends on the first bvalid sampled after both AW and W have completed; err |= bresp.
  - A bvalid arriving before both handshakes complete is a protocol violation, ignored for sequencing.
  - WR_A completes to WR_B (awaddr=OPB_ADDR, wdata=B). WR_B completes to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to RD. SETTLE_CYCLES=0 goes to RD on the next cycle.
- RD: arvalid=1, araddr=RES_ADDR. arvalid drops the cycle after arready. rready=1 only after the AR handshake. On rvalid&rready: rsp_sum<=rdata, err |= rresp, go RESP.
- RESP: rsp_valid=1, rsp_sum/rsp_err stable until rsp_valid&rsp_ready, then IDLE. cmd_ready is 0 in every state except IDLE (no overlap of commands).
- An error does not abort the sequence; all three transactions always run.
- Minimum latency with an always-ready slave, SETTLE_CYCLES=2, from cmd accept to rsp_valid: 10 cycles. A bench checks the exact count.
- Reset mid-transaction: immediate return to reset values; the latched command is discarded and no response is produced.

Decomposition:
- Shared package adder_axi_pkg: state enum, default register address constants (OPA/OPB/RES), and response encoding constant (error=1).
- One sub-module, axi_lite_wr_chan: it drives AW+W with independent handshake tracking and a B wait, and is instantiated once and reused for both writes via address/data inputs.

Test Plan:
- Always-ready slave model, A=39, B=40 -> writes 39@0 then 40@4; read @24 returns 79; rsp_sum=79, rsp_err=0, latency 10 cycles.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held with a stable address until its handshake; result correct.
- Slave returns bresp=1 on the second write -> all three transactions still occur; rsp_err=1.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_sum stable; cmd_ready stays 0; a new cmd_valid is not accepted until the response is consumed.
- Reset asserted during WR_B with awvalid high -> all valids 0 immediately; after release cmd_ready=1 and no rsp_valid is ever produced.
- A=32'hFFFF_FFFF, B=1 against the adder slave -> rsp_sum=0 (wrap-around), rsp_err=0.
